// File: rtl/stream_mux_pkg.sv
// Shared constants for the stream multiplexer family: selection modes and the
// select/index width helper.
package stream_mux_pkg;

  localparam int MODE_FIXED = 0;
  localparam int MODE_RR    = 1;

  // Index width for n channels; a 2-channel mux still needs one select bit.
  function automatic int sw_of(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/stream_mux_n_if.sv
// Handshake bundle for stream_mux_n: N input channels, one registered output.
interface stream_mux_n_if
  import stream_mux_pkg::*;
#(
  parameter int N = 4,
  parameter int W = 8
);
  localparam int SW = sw_of(N);

  logic [N-1:0]   in_val;
  logic [N-1:0]   in_rdy;
  logic [N*W-1:0] in_data;
  logic [SW-1:0]  sel;
  logic           out_val;
  logic           out_rdy;
  logic [W-1:0]   out_data;
  logic [SW-1:0]  out_src;

  modport master (
    output in_val, in_data, sel, out_rdy,
    input  in_rdy, out_val, out_data, out_src
  );

  modport slave (
    input  in_val, in_data, sel, out_rdy,
    output in_rdy, out_val, out_data, out_src
  );

endinterface

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: grants the first requester at or after ptr, wrapping,
// and advances ptr past the granted channel on each accepted transfer.
module rr_arbiter
  import stream_mux_pkg::*;
#(
  parameter  int N  = 4,
  localparam int SW = sw_of(N)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [N-1:0]  req,
  input  logic          adv,
  output logic [N-1:0]  gnt,
  output logic [SW-1:0] gnt_idx
);

  logic [SW-1:0] ptr;
  logic          found;

  // Two passes avoid modulo arithmetic: channels ptr..N-1 first, then 0..ptr-1.
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    for (int unsigned i = 0; i < N; i++) begin
      if (!found && req[i] && (i >= 32'(ptr))) begin
        found   = 1'b1;
        gnt[i]  = 1'b1;
        gnt_idx = SW'(i);
      end
    end
    for (int unsigned i = 0; i < N; i++) begin
      if (!found && req[i]) begin
        found   = 1'b1;
        gnt[i]  = 1'b1;
        gnt_idx = SW'(i);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr <= '0;
    end else if (adv) begin
      ptr <= (gnt_idx == SW'(N - 1)) ? '0 : gnt_idx + SW'(1);
    end
  end

endmodule

// File: rtl/stream_mux_n.sv
// N-way registered stream multiplexer with fixed-select or round-robin grant
// and a single valid/ready output register.
module stream_mux_n
  import stream_mux_pkg::*;
#(
  parameter  int N    = 4,
  parameter  int W    = 8,
  parameter  int MODE = MODE_FIXED,
  localparam int SW   = sw_of(N)
) (
  input  logic          clk,
  input  logic          rst,
  stream_mux_n_if.slave bus
);

  logic [N-1:0]  grant;
  logic [SW-1:0] gnt_idx;
  logic          load;
  logic          accept;
  logic [W-1:0]  mux_data;

  assign load        = !bus.out_val || bus.out_rdy;
  assign bus.in_rdy  = grant & {N{load}};
  assign accept      = |(bus.in_val & bus.in_rdy);

  // Grant never looks at in_rdy, so in_rdy -> grant has no combinational path.
  if (MODE == MODE_RR) begin : g_rr
    rr_arbiter #(.N(N)) u_arb (
      .clk     (clk),
      .rst     (rst),
      .req     (bus.in_val),
      .adv     (accept),
      .gnt     (grant),
      .gnt_idx (gnt_idx)
    );
  end else begin : g_fixed
    always_comb begin
      grant = '0;
      for (int unsigned i = 0; i < N; i++) begin
        grant[i] = (32'(bus.sel) == i);
      end
      gnt_idx = bus.sel;
    end
  end

  always_comb begin
    mux_data = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (grant[i]) begin
        mux_data = bus.in_data[i*W +: W];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.out_val  <= 1'b0;
      bus.out_data <= '0;
      bus.out_src  <= '0;
    end else if (load) begin
      bus.out_val <= accept;
      if (accept) begin
        bus.out_data <= mux_data;
        bus.out_src  <= gnt_idx;
      end
    end
  end

endmodule

// File: tb/tb_stream_mux_n.sv
// Directed bench for stream_mux_n: fixed N=4, round-robin N=4 and fixed N=3.
module tb_stream_mux_n;
  import stream_mux_pkg::*;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_bad;

  stream_mux_n_if #(.N(4), .W(8)) fb ();
  stream_mux_n_if #(.N(4), .W(8)) rb ();
  stream_mux_n_if #(.N(3), .W(8)) tb3 ();

  stream_mux_n #(.N(4), .W(8), .MODE(MODE_FIXED)) u_fix4 (.clk(clk), .rst(rst), .bus(fb));
  stream_mux_n #(.N(4), .W(8), .MODE(MODE_RR))    u_rr4  (.clk(clk), .rst(rst), .bus(rb));
  stream_mux_n #(.N(3), .W(8), .MODE(MODE_FIXED)) u_fix3 (.clk(clk), .rst(rst), .bus(tb3));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  val;
    logic [31:0] data;
    logic [1:0]  sel;
    logic        ordy;
    logic [3:0]  e_rdy;
    logic        e_val;
    logic [7:0]  e_data;
    logic [1:0]  e_src;
  } vec_t;

  vec_t fv [11];
  vec_t rv [13];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic run_vec(input vec_t v, input bit rr, input int k);
    string tag;
    tag = rr ? $sformatf("rr[%0d]", k) : $sformatf("fix[%0d]", k);
    @(negedge clk);
    if (rr) begin
      rb.in_val = v.val; rb.in_data = v.data; rb.sel = v.sel; rb.out_rdy = v.ordy;
    end else begin
      fb.in_val = v.val; fb.in_data = v.data; fb.sel = v.sel; fb.out_rdy = v.ordy;
    end
    #1;
    chk({tag, " in_rdy"}, 32'(rr ? rb.in_rdy : fb.in_rdy), 32'(v.e_rdy));
    @(posedge clk);
    #1;
    chk({tag, " out_val"},  32'(rr ? rb.out_val  : fb.out_val),  32'(v.e_val));
    chk({tag, " out_data"}, 32'(rr ? rb.out_data : fb.out_data), 32'(v.e_data));
    chk({tag, " out_src"},  32'(rr ? rb.out_src  : fb.out_src),  32'(v.e_src));
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;

    //           val      data           sel  rdy  e_rdy    e_val e_data e_src
    fv[0]  = '{4'b0100, 32'h0011_0000, 2'd2, 1'b1, 4'b0100, 1'b1, 8'h11, 2'd2};
    fv[1]  = '{4'b0100, 32'h0022_0000, 2'd2, 1'b1, 4'b0100, 1'b1, 8'h22, 2'd2};
    fv[2]  = '{4'b0100, 32'h0033_0000, 2'd2, 1'b1, 4'b0100, 1'b1, 8'h33, 2'd2};
    fv[3]  = '{4'b0001, 32'h0000_0044, 2'd0, 1'b0, 4'b0000, 1'b1, 8'h33, 2'd2};
    fv[4]  = '{4'b0001, 32'h0000_0044, 2'd0, 1'b0, 4'b0000, 1'b1, 8'h33, 2'd2};
    fv[5]  = '{4'b0001, 32'h0000_0044, 2'd0, 1'b1, 4'b0001, 1'b1, 8'h44, 2'd0};
    fv[6]  = '{4'b0000, 32'h0000_0000, 2'd0, 1'b1, 4'b0001, 1'b0, 8'h44, 2'd0};
    fv[7]  = '{4'b0000, 32'h0000_0000, 2'd0, 1'b0, 4'b0001, 1'b0, 8'h44, 2'd0};
    fv[8]  = '{4'b1000, 32'h5A00_0000, 2'd3, 1'b0, 4'b1000, 1'b1, 8'h5A, 2'd3};
    fv[9]  = '{4'b1000, 32'h7700_0000, 2'd3, 1'b0, 4'b0000, 1'b1, 8'h5A, 2'd3};
    fv[10] = '{4'b0000, 32'h7700_0000, 2'd3, 1'b1, 4'b1000, 1'b0, 8'h5A, 2'd3};

    rv[0]  = '{4'b1111, 32'hD3D2_D1D0, 2'd0, 1'b1, 4'b0001, 1'b1, 8'hD0, 2'd0};
    rv[1]  = '{4'b1111, 32'hD3D2_D1D0, 2'd0, 1'b1, 4'b0010, 1'b1, 8'hD1, 2'd1};
    rv[2]  = '{4'b1111, 32'hD3D2_D1D0, 2'd0, 1'b1, 4'b0100, 1'b1, 8'hD2, 2'd2};
    rv[3]  = '{4'b1111, 32'hD3D2_D1D0, 2'd0, 1'b1, 4'b1000, 1'b1, 8'hD3, 2'd3};
    rv[4]  = '{4'b1111, 32'hD3D2_D1D0, 2'd0, 1'b1, 4'b0001, 1'b1, 8'hD0, 2'd0};
    rv[5]  = '{4'b1111, 32'hD3D2_D1D0, 2'd0, 1'b1, 4'b0010, 1'b1, 8'hD1, 2'd1};
    rv[6]  = '{4'b1010, 32'hD3D2_D1D0, 2'd0, 1'b1, 4'b1000, 1'b1, 8'hD3, 2'd3};
    rv[7]  = '{4'b1010, 32'hD3D2_D1D0, 2'd0, 1'b1, 4'b0010, 1'b1, 8'hD1, 2'd1};
    rv[8]  = '{4'b1010, 32'hD3D2_D1D0, 2'd0, 1'b1, 4'b1000, 1'b1, 8'hD3, 2'd3};
    rv[9]  = '{4'b0000, 32'hD3D2_D1D0, 2'd0, 1'b1, 4'b0000, 1'b0, 8'hD3, 2'd3};
    rv[10] = '{4'b1010, 32'hD3D2_D1D0, 2'd0, 1'b0, 4'b0010, 1'b1, 8'hD1, 2'd1};
    rv[11] = '{4'b1010, 32'hD3D2_D1D0, 2'd0, 1'b0, 4'b0000, 1'b1, 8'hD1, 2'd1};
    rv[12] = '{4'b1010, 32'hD3D2_D1D0, 2'd0, 1'b1, 4'b1000, 1'b1, 8'hD3, 2'd3};

    fb.in_val = '0;  fb.in_data = '0;  fb.sel = '0;  fb.out_rdy = 1'b0;
    rb.in_val = '0;  rb.in_data = '0;  rb.sel = '0;  rb.out_rdy = 1'b0;
    tb3.in_val = '0; tb3.in_data = '0; tb3.sel = '0; tb3.out_rdy = 1'b0;

    rst = 1'b0;
    #1 rst = 1'b1;
    #1;
    chk("reset fix4 out_val",  32'(fb.out_val),   32'd0);
    chk("reset fix4 out_data", 32'(fb.out_data),  32'd0);
    chk("reset fix4 out_src",  32'(fb.out_src),   32'd0);
    chk("reset rr4 out_val",   32'(rb.out_val),   32'd0);
    chk("reset rr4 in_rdy",    32'(rb.in_rdy),    32'd0);
    chk("reset fix3 out_val",  32'(tb3.out_val),  32'd0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 11; i++) run_vec(fv[i], 1'b0, i);
    for (int i = 0; i < 13; i++) run_vec(rv[i], 1'b1, i);

    // Load words into both muxes, then reset between clock edges.
    @(negedge clk);
    fb.sel = 2'd1; fb.in_val = 4'b0010; fb.in_data = 32'h0000_A500; fb.out_rdy = 1'b0;
    rb.in_val = 4'b0100; rb.in_data = 32'hD3D2_D1D0; rb.out_rdy = 1'b1;
    @(posedge clk);
    #1;
    chk("pre-rst fix4 out_val",  32'(fb.out_val),  32'd1);
    chk("pre-rst fix4 out_data", 32'(fb.out_data), 32'hA5);
    chk("pre-rst fix4 out_src",  32'(fb.out_src),  32'd1);
    chk("pre-rst rr4 out_src",   32'(rb.out_src),  32'd2);
    @(negedge clk);
    fb.in_val = '0;
    rb.in_val = '0; rb.out_rdy = 1'b0;
    #1 rst = 1'b1;
    #1;
    chk("midrst fix4 out_val",  32'(fb.out_val),  32'd0);
    chk("midrst fix4 out_data", 32'(fb.out_data), 32'd0);
    chk("midrst fix4 out_src",  32'(fb.out_src),  32'd0);
    chk("midrst rr4 out_val",   32'(rb.out_val),  32'd0);
    chk("midrst rr4 out_src",   32'(rb.out_src),  32'd0);
    #1 rst = 1'b0;
    rb.in_val = 4'b1111; rb.out_rdy = 1'b1;
    #1;
    chk("postrst rr4 in_rdy", 32'(rb.in_rdy), 32'b0001);
    @(posedge clk);
    #1;
    chk("postrst rr4 out_src",  32'(rb.out_src),  32'd0);
    chk("postrst rr4 out_data", 32'(rb.out_data), 32'hD0);
    chk("postrst rr4 out_val",  32'(rb.out_val),  32'd1);
    @(negedge clk);
    rb.in_val = '0;

    // N=3 with sel out of range: no channel may ever be ready.
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      tb3.sel = 2'd3; tb3.in_val = 3'b111; tb3.in_data = 24'h33_22_11; tb3.out_rdy = 1'b1;
      #1;
      chk($sformatf("fix3 oor[%0d] in_rdy", i), 32'(tb3.in_rdy), 32'd0);
      @(posedge clk);
      #1;
      chk($sformatf("fix3 oor[%0d] out_val", i), 32'(tb3.out_val), 32'd0);
    end
    @(negedge clk);
    tb3.sel = 2'd1;
    #1;
    chk("fix3 sel1 in_rdy", 32'(tb3.in_rdy), 32'b010);
    @(posedge clk);
    #1;
    chk("fix3 sel1 out_val",  32'(tb3.out_val),  32'd1);
    chk("fix3 sel1 out_data", 32'(tb3.out_data), 32'h22);
    chk("fix3 sel1 out_src",  32'(tb3.out_src),  32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
    $finish;
  end

endmodule
